// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared word/address widths, requester count and forwarding helper
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef RA_LEN
`define RA_LEN [4:0]
`endif
package regfile_wb_arbiter_pkg;
  localparam int N_REQ = 2;
  typedef logic `RA_LEN ra_t;
  typedef logic [`WORD_LEN-1:0] word_t;
  localparam int WORD_W = $bits(word_t);
  // Returns {hit, data}; on a double match the younger slot wins, slot 0 being older when old0 is set.
  function automatic logic [WORD_W:0] fwd_sel(input ra_t ra, input logic [1:0] v, input ra_t a0,
                                               input ra_t a1, input word_t d0, input word_t d1,
                                               input logic old0);
    logic m0, m1;
    m0 = v[0] && a0 == ra && ra != '0;
    m1 = v[1] && a1 == ra && ra != '0;
    return (m1 && (!m0 || old0)) ? {1'b1, d1} : m0 ? {1'b1, d0} : '0;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// wb_slot: one pending write-back entry (valid, address, data, age) with load and clear
module wb_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  clr_i,
  input  ra_t   wa_i,
  input  word_t wd_i,
  input  logic  age_i,
  output logic  valid_o,
  output ra_t   wa_o,
  output word_t wd_o,
  output logic  age_o
);
  logic  valid_q, valid_d, age_q;
  ra_t   wa_q, wa_d;
  word_t wd_q, wd_d;
  always_comb begin
    valid_d = load_i ? 1'b1 : clr_i ? 1'b0 : valid_q;
    wa_d    = load_i ? wa_i : wa_q;
    wd_d    = load_i ? wd_i : wd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      age_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      age_q   <= age_i;
    end
  end
  assign valid_o = valid_q;
  assign wa_o    = wa_q;
  assign wd_o    = wd_q;
  assign age_o   = age_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-slot write-back arbiter onto one regfile port; forwarding under REGFILE_WB_FWD_EN
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic `RA_LEN         req0_wa,
  input  logic `RA_LEN         req1_wa,
  input  logic [`WORD_LEN-1:0] req0_wd,
  input  logic [`WORD_LEN-1:0] req1_wd,
  output logic                 we3,
  output logic `RA_LEN         wa3,
  output logic [`WORD_LEN-1:0] wd3,
  input  logic `RA_LEN         ra1,
  input  logic `RA_LEN         ra2,
  output logic                 fwd1_hit,
  output logic                 fwd2_hit,
  output logic [`WORD_LEN-1:0] fwd1_data,
  output logic [`WORD_LEN-1:0] fwd2_data
);
  logic [N_REQ-1:0] req_v, vld, ld, clr, gnt, age, rdy;
  ra_t   in_wa [N_REQ];
  ra_t   s_wa  [N_REQ];
  word_t in_wd [N_REQ];
  word_t s_wd  [N_REQ];
  logic  g1, both, old0_d, last1_q, last1_d;
  assign req_v    = {req1_valid, req0_valid};
  assign in_wa[0] = req0_wa;
  assign in_wa[1] = req1_wa;
  assign in_wd[0] = req0_wd;
  assign in_wd[1] = req1_wd;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    wb_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (ld[i]),
      .clr_i   (clr[i]),
      .wa_i    (in_wa[i]),
      .wd_i    (in_wd[i]),
      .age_i   (i == 0 ? old0_d : !old0_d),
      .valid_o (vld[i]),
      .wa_o    (s_wa[i]),
      .wd_o    (s_wd[i]),
      .age_o   (age[i])
    );
  end
  // age[k] marks slot k as the older entry; last1_q remembers whether slot 1 won the last contested grant.
  always_comb begin
    both    = vld[0] && vld[1];
    g1      = vld[1] && (both ? (s_wa[0] == s_wa[1] ? age[1] : !last1_q) : 1'b1);
    gnt     = {g1, vld[0] && !g1};
    rdy     = ~vld | gnt;
    ld[0]   = req_v[0] && rdy[0] && in_wa[0] != '0;
    ld[1]   = req_v[1] && rdy[1] && in_wa[1] != '0;
    clr     = gnt & ~ld;
    last1_d = both ? g1 : last1_q;
    old0_d  = ld[1] ? 1'b1 : ld[0] ? 1'b0 : age[0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last1_q <= 1'b1;
    else        last1_q <= last1_d;
  end
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign we3        = |vld;
  assign wa3        = g1 ? s_wa[1] : gnt[0] ? s_wa[0] : '0;
  assign wd3        = g1 ? s_wd[1] : gnt[0] ? s_wd[0] : '0;
`ifdef REGFILE_WB_FWD_EN
  assign {fwd1_hit, fwd1_data} = fwd_sel(ra1, vld, s_wa[0], s_wa[1], s_wd[0], s_wd[1], age[0]);
  assign {fwd2_hit, fwd2_data} = fwd_sel(ra2, vld, s_wa[0], s_wa[1], s_wd[0], s_wd[1], age[0]);
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign {fwd1_hit, fwd1_data} = '0;
  assign {fwd2_hit, fwd2_data} = '0;
`endif
endmodule
